bist_mem_responder: RTL
=======================

Name: bist_mem_responder

Overview:
Memory-side responder for the BIST controller: a DEPTH x DATA_W two-port (1 write, 1 read) array that services either functional traffic or BIST traffic, selected by bist_en. It returns registered read data with a valid strobe to the BIST comparator. It also provides a hardware clear sweep so every BIST run starts from a known array state.

Parameters:
ADDR_W, 5, address width of both ports
DATA_W, 8, data width
DEPTH, 32, number of words (legal range 2..2**ADDR_W)
RD_LAT, 1, read latency in cycles from accepted read to data_valid (legal values 1 or 2)

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
bist_en  in  1  1 = BIST port owns the array, 0 = functional port owns it
init_req  in  1  one-cycle pulse that starts the clear sweep
func_write_en  in  1  functional write strobe
func_write_addr  in  ADDR_W  functional write address
func_data_in  in  DATA_W  functional write data
func_read_en  in  1  functional read strobe
func_read_addr  in  ADDR_W  functional read address
bistwrite_en_in  in  1  BIST write strobe
bistwrite_addr_in  in  ADDR_W  BIST write address
bistd_in  in  DATA_W  BIST write data
bistread_en_in  in  1  BIST read strobe
bistread_addr_in  in  ADDR_W  BIST read address
data_out  out  DATA_W  read data, stable until the next valid
data_valid  out  1  one-cycle strobe qualifying data_out
busy  out  1  high during CLEAR or GUARD; all port accesses are dropped while high
oob_err  out  1  sticky flag, set by any accepted access with address >= DEPTH

Behaviour:
- Reset (reset_n low, async): data_out=0, data_valid=0, busy=0, oob_err=0, FSM=IDLE, read pipeline flushed, bist_en_q=0. Array contents are not reset.
- FSM states: IDLE, CLEAR, GUARD.
- IDLE -> CLEAR on init_req. CLEAR writes 0 to address clr_cnt, one address per cycle, starting at 0. Exits after DEPTH-1, so CLEAR lasts DEPTH cycles and busy is high for those cycles. CLEAR -> GUARD.
- IDLE -> GUARD when bist_en != bist_en_q, i.e. on an ownership change. GUARD lasts exactly 1 cycle, updates bist_en_q, then returns to IDLE.
- init_req in the same cycle as a bist_en change: CLEAR takes priority; the following GUARD also absorbs the ownership change.
- init_req while busy is ignored.
- In IDLE, the port selected by bist_en_q is the active port; the other port's strobes are ignored.
- Write: accepted when the strobe is high and the address is < DEPTH. The array updates at the clock edge.
- Read: accepted address is captured into the pipeline. With RD_LAT=1, data_out/data_valid appear on the next edge; with RD_LAT=2, one edge later.
- Read and write to the same address in the same cycle: read-before-write, so the read returns the old word.
- Out-of-range access (address >= DEPTH): the write is dropped. The read still produces data_valid with data_out=0. oob_err is set and held until reset.
- Reads accepted before busy rises still complete through the pipeline; no new reads are accepted while busy.
- data_valid is never high for two consecutive cycles unless reads are accepted back-to-back; full throughput is one read per cycle.
- reset_n asserted mid-CLEAR aborts the sweep; the array is left partially cleared.

Optional Feature:
- Macro: BIST_MEM_FAULT_INJECT_EN.
- When defined, four extra inputs are added: fault_en (1), fault_addr (ADDR_W), fault_bit ($clog2(DATA_W)), fault_val (1). While fault_en=1, any read of fault_addr returns the stored word with bit fault_bit forced to fault_val, which models a stuck-at fault for BIST coverage. Writes and the stored contents are unaffected.
- When not defined, these ports and the forcing logic are absent and reads return stored data unmodified.

Decomposition:
- Package bist_mem_pkg holds the FSM state enum (IDLE/CLEAR/GUARD), the ADDR_W/DATA_W/DEPTH defaults, and the RD_LAT legality constant.
- One sub-module, bist_mem_array: a pure storage array with one write port and one read port, no reset, read-before-write. The port mux, FSM, read pipeline and fault logic stay in the top level.

Test Plan:
- Reset, then init_req with bist_en=0 -> busy high for 32 cycles, then GUARD for 1 cycle; a read of each address 0..31 returns 0x00 with data_valid.
- bist_en 0->1, BIST writes 0xA5 to addr 7, then reads addr 7 (RD_LAT=1) -> busy high for 1 cycle after the switch; data_out=0xA5 with data_valid one cycle after the read strobe. A functional write to addr 7 in the same window leaves the word at 0xA5.
- Same-cycle BIST write 0x3C and read of addr 3, which holds 0x11 -> data_out=0x11; the next read of addr 3 returns 0x3C.
- DEPTH=24, BIST write to addr 30 then read addr 30 -> array unchanged, data_out=0x00 with data_valid, oob_err=1 until reset_n is pulsed.
- Back-to-back BIST reads of addrs 0,1,2 with RD_LAT=2 -> data_valid high for 3 consecutive cycles starting 2 cycles after the first read; reset_n pulsed during the 2nd cycle of CLEAR -> all outputs are 0 immediately.
- With BIST_MEM_FAULT_INJECT_EN: fault_addr=5, fault_bit=0, fault_val=1, word 0x00 at addr 5 -> a read returns 0x01; with fault_en=0 the read returns 0x00.

Source files
------------

// File: rtl/bist_mem_pkg.sv
// Shared constants and FSM encoding for the BIST memory responder.
// Optional fault injection in the top level is enabled by BIST_MEM_FAULT_INJECT_EN.
package bist_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned RD_LAT_DEF = 1;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_GUARD = 2'd2;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/bist_mem_array.sv
// Storage array: one write port, one combinational read port, no reset.
// Reads see the pre-edge contents, so a same-cycle read/write returns the old word.
module bist_mem_array #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bist_mem_responder.sv
// Memory-side responder for the BIST controller: port mux, clear sweep, ownership guard,
// registered read pipeline. Define BIST_MEM_FAULT_INJECT_EN to add stuck-at read forcing.
module bist_mem_responder
  import bist_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_bist_en,
  input  logic                       i_init_req,
  input  logic                       i_func_write_en,
  input  logic [ADDR_W-1:0]          i_func_write_addr,
  input  logic [DATA_W-1:0]          i_func_data_in,
  input  logic                       i_func_read_en,
  input  logic [ADDR_W-1:0]          i_func_read_addr,
  input  logic                       i_bistwrite_en_in,
  input  logic [ADDR_W-1:0]          i_bistwrite_addr_in,
  input  logic [DATA_W-1:0]          i_bistd_in,
  input  logic                       i_bistread_en_in,
  input  logic [ADDR_W-1:0]          i_bistread_addr_in,
`ifdef BIST_MEM_FAULT_INJECT_EN
  input  logic                       i_fault_en,
  input  logic [ADDR_W-1:0]          i_fault_addr,
  input  logic [$clog2(DATA_W)-1:0]  i_fault_bit,
  input  logic                       i_fault_val,
`endif
  output logic [DATA_W-1:0]          o_data_out,
  output logic                       o_data_valid,
  output logic                       o_busy,
  output logic                       o_oob_err
);

  // Out-of-range latency values fall back to a single pipeline stage.
  localparam bit LAT2 = rd_lat_legal(RD_LAT) && (RD_LAT == RD_LAT_MAX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic              r_bist_en_q, w_bist_en_nxt;
  logic              r_oob_err;
  logic              r_data_valid;
  logic [DATA_W-1:0] r_data_out;

  logic              w_idle, w_clear;
  logic              w_port_we, w_port_re;
  logic [ADDR_W-1:0] w_port_waddr, w_port_raddr;
  logic [DATA_W-1:0] w_port_wdata;
  logic              w_wr_acc, w_rd_acc;
  logic              w_waddr_ok, w_raddr_ok;

  logic              w_arr_we;
  logic [ADDR_W-1:0] w_arr_waddr;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [DATA_W-1:0] w_arr_rdata;
  logic [DATA_W-1:0] w_arr_word;
  logic [DATA_W-1:0] w_rd_data;

  logic              w_out_vld;
  logic [DATA_W-1:0] w_out_data;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_clear = (r_state == ST_CLEAR);

  always_comb begin
    w_port_we    = 1'b0;
    w_port_waddr = '0;
    w_port_wdata = '0;
    w_port_re    = 1'b0;
    w_port_raddr = '0;
    if (r_bist_en_q) begin
      w_port_we    = i_bistwrite_en_in;
      w_port_waddr = i_bistwrite_addr_in;
      w_port_wdata = i_bistd_in;
      w_port_re    = i_bistread_en_in;
      w_port_raddr = i_bistread_addr_in;
    end else begin
      w_port_we    = i_func_write_en;
      w_port_waddr = i_func_write_addr;
      w_port_wdata = i_func_data_in;
      w_port_re    = i_func_read_en;
      w_port_raddr = i_func_read_addr;
    end
  end

  assign w_wr_acc   = w_idle & w_port_we;
  assign w_rd_acc   = w_idle & w_port_re;
  assign w_waddr_ok = (32'(w_port_waddr) < DEPTH);
  assign w_raddr_ok = (32'(w_port_raddr) < DEPTH);

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_bist_en_nxt = r_bist_en_q;
    unique case (r_state)
      ST_IDLE: begin
        // Clear wins over an ownership change; the GUARD after CLEAR absorbs it.
        if (i_init_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end else if (i_bist_en != r_bist_en_q) begin
          w_state_nxt = ST_GUARD;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt   = ST_GUARD;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      ST_GUARD: begin
        w_bist_en_nxt = i_bist_en;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_clr_cnt   <= '0;
      r_bist_en_q <= 1'b0;
      r_oob_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_bist_en_q <= w_bist_en_nxt;
      r_oob_err   <= r_oob_err | (w_wr_acc & ~w_waddr_ok) | (w_rd_acc & ~w_raddr_ok);
    end
  end

  assign w_arr_we    = w_clear | (w_wr_acc & w_waddr_ok);
  assign w_arr_waddr = w_clear ? r_clr_cnt : w_port_waddr;
  assign w_arr_wdata = w_clear ? '0 : w_port_wdata;

  bist_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_raddr (w_port_raddr),
    .o_rdata (w_arr_rdata)
  );

`ifdef BIST_MEM_FAULT_INJECT_EN
  always_comb begin
    w_arr_word = w_arr_rdata;
    if (i_fault_en && (i_fault_addr == w_port_raddr)) begin
      w_arr_word[i_fault_bit] = i_fault_val;
    end
  end
`else
  assign w_arr_word = w_arr_rdata;
`endif

  assign w_rd_data = w_raddr_ok ? w_arr_word : '0;

  if (LAT2) begin : g_lat2
    logic              r_p1_vld;
    logic [DATA_W-1:0] r_p1_data;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_p1_vld  <= 1'b0;
        r_p1_data <= '0;
      end else begin
        r_p1_vld <= w_rd_acc;
        if (w_rd_acc) begin
          r_p1_data <= w_rd_data;
        end
      end
    end

    assign w_out_vld  = r_p1_vld;
    assign w_out_data = r_p1_data;
  end else begin : g_lat1
    assign w_out_vld  = w_rd_acc;
    assign w_out_data = w_rd_data;
  end

  // data_out only moves with a valid strobe so it holds between reads.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_data_valid <= w_out_vld;
      if (w_out_vld) begin
        r_data_out <= w_out_data;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_busy       = ~w_idle;
  assign o_oob_err    = r_oob_err;

endmodule
